// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO result
// registers. Executes MULTU, MULT, DIVU, DIV (WIDTH cycles plus one fix-up
// cycle), and MTHI/MTLO (written directly on the accept edge).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               res_neg;   // negate product / quotient at FIN
    logic               rem_neg;   // negate remainder at FIN
    logic               dz_pend;   // divide by zero pending for FIN

    // Opcode decode: op[2]=move-to, op[1]=divide, op[0]=signed
    logic is_mt;
    logic is_nop;
    logic is_sgn;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Datapath step results and final sign fix-ups
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand decode and absolute values; the negation wraps at WIDTH bits, so
    // the most-negative value becomes the unsigned 2^(WIDTH-1)
    always_comb begin
        is_mt  = op[2] & ~op[1];
        is_nop = op[2] & op[1];
        is_sgn = op[0] & ~op[2];
        a_abs  = (is_sgn && a[WIDTH-1]) ? -a : a;
        b_abs  = (is_sgn && b[WIDTH-1]) ? -b : b;
    end

    // One shift/add or restoring shift/subtract step, plus the FIN sign fix
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opnd});
        // When div_ge holds the true difference is below the divisor, so the
        // low WIDTH bits of the subtraction are exact.
        div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
        prod_fix     = res_neg ? -acc : acc;
        quo_fix      = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix      = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered outputs and the iterative datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            // NOTE: done defaults low every edge so it can only ever be a single-cycle pulse.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !is_nop) begin
                        div_by_zero <= 1'b0;
                        if (is_mt) begin
                            if (op[0]) lo <= a;
                            else       hi <= a;
                        end else begin
                            busy    <= 1'b1;
                            is_div  <= op[1];
                            res_neg <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg <= is_sgn & a[WIDTH-1];
                            count   <= CW'(WIDTH);
                            if (op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, a_abs};
                                opnd <= b_abs;
                                if (b == '0) begin
                                    dz_pend <= 1'b1;
                                    state   <= FIN;
                                end else begin
                                    dz_pend <= 1'b0;
                                    state   <= RUN;
                                end
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, b_abs};
                                opnd    <= a_abs;
                                dz_pend <= 1'b0;
                                state   <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (is_div) acc <= {div_rem_next, acc[WIDTH-2:0], div_ge};
                    else        acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (count == CW'(1)) state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz_pend) begin
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32 and WIDTH=8).
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div_by_zero8;
    logic [7:0]  hi8, lo8;

    int checks   = 0;
    int failures = 0;
    int n, bc, dcnt;

    localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001, DIVU = 3'b010,
                           DIV = 3'b011, MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b110;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_by_zero(div_by_zero8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge: present a request for one edge, then scramble operands
    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for done; optionally pokes a new start at cycle poke_at
    task automatic wait_done(input int poke_at, output int cyc, output int busy_cyc);
        cyc = 0; busy_cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 100) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (!done8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check("done8_timeout", {63'd0, done8}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #1;
        check("reset_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max x max: latency, busy length, result, single-cycle done
        go(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(-1, n, bc);
        check("multu_latency", n, 64'd33);
        check("multu_busy_cycles", bc, 64'd33);
        check("multu_busy_at_done", {63'd0, busy}, 64'd0);
        check("multu_result", {hi, lo}, 64'hFFFFFFFE_00000001);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // MULT -3 x 5
        go(MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(-1, n, bc);
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        // DIV -7 / 2
        go(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(-1, n, bc);
        check("div_neg_latency", n, 64'd33);
        check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        // DIVU 7 / 2
        go(DIVU, 32'd7, 32'd2);
        wait_done(-1, n, bc);
        check("divu_7_2", {hi, lo}, 64'h00000001_00000003);

        // DIV most-negative / -1
        go(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(-1, n, bc);
        check("div_minneg_m1", {hi, lo}, 64'h00000000_80000000);

        // MTHI / MTLO: immediate, no busy
        go(MTHI, 32'h11, 32'h0);
        check("mthi", {32'd0, hi}, 64'h11);
        check("mthi_no_busy", {62'd0, busy, done}, 64'd0);
        go(MTLO, 32'h22, 32'h0);
        check("mtlo", {hi, lo}, 64'h00000011_00000022);

        // DIVU 7 / 0: one-cycle completion, flag, HI/LO unchanged
        go(DIVU, 32'd7, 32'd0);
        wait_done(-1, n, bc);
        check("dz_latency", n, 64'd1);
        check("dz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dz_hilo_kept", {hi, lo}, 64'h00000011_00000022);
        @(negedge clk);
        check("dz_flag_held", {62'd0, div_by_zero, done}, 64'd2);

        // 11x op is ignored entirely
        go(NOP, 32'h55, 32'h55);
        check("nop_no_busy", {63'd0, busy}, 64'd0);
        check("nop_hilo_kept", {hi, lo}, 64'h00000011_00000022);

        // Next accepted start clears the flag
        go(DIVU, 32'd100, 32'd7);
        check("dz_cleared", {62'd0, div_by_zero, busy}, 64'd1);
        wait_done(-1, n, bc);
        check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);

        // start while busy is ignored
        go(MULTU, 32'd3, 32'd5);
        wait_done(5, n, bc);
        check("busy_ignore_latency", n, 64'd33);
        check("busy_ignore_result", {hi, lo}, 64'h00000000_0000000F);
        @(negedge clk);
        check("busy_ignore_no_run", {62'd0, busy, done}, 64'd0);

        // Back-to-back: start in the done cycle is accepted
        go(MULTU, 32'd6, 32'd7);
        wait_done(-1, n, bc);
        check("b2b_first", {hi, lo}, 64'h00000000_0000002A);
        go(MULT, 32'hFFFFFFFE, 32'd3);
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        wait_done(-1, n, bc);
        check("b2b_latency", n, 64'd33);
        check("b2b_second", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

        // Reset mid-run
        go(MULT, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("rst_no_done", dcnt, 64'd0);
        check("rst_idle", {63'd0, busy}, 64'd0);

        // WIDTH=8 instance
        start8 = 1'b1; op8 = MULT; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h3C; b8 = 8'hA5;
        wait_done8(n);
        check("w8_mult_latency", n, 64'd9);
        check("w8_mult", {48'd0, hi8, lo8}, 64'h4000);
        start8 = 1'b1; op8 = DIV; a8 = 8'h80; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        wait_done8(n);
        check("w8_div", {48'd0, hi8, lo8}, 64'h0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO result registers. It executes MIPS-style MULT, MULTU, DIV, DIVU, MTHI and MTLO on WIDTH-bit operands. It sits beside the combinational ALU in the execute stage, and the pipeline stalls on `busy`. Multiply and divide use a radix-2 shift/add and shift/subtract datapath, one bit per cycle, with a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand and HI/LO width; legal values are 8..64.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled on the rising edge, accepted only when `busy`=0.
- `op`  in  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- `a`  in  WIDTH  multiplicand / dividend / MTHI–MTLO source.
- `b`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  operation in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this same cycle.
- `div_by_zero`  out  1  set with `done` for a divide with `b`=0; cleared on the next accepted `start`.
- `hi`  out  WIDTH  HI register: product upper half / remainder.
- `lo`  out  WIDTH  LO register: product lower half / quotient.

## Operation
- States: IDLE, RUN, FIN.
- **Reset**: forces IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, iteration counter=0.
- **Accept edge** (IDLE with `start`=1):
  - Latch `op`, `a` and `b`; later changes on the inputs have no effect.
  - MULT/DIV: take absolute values of both operands. Record the result sign (`a[W-1]^b[W-1]`) and the remainder sign (`a[W-1]`).
  - MULTU/MULT, and DIVU/DIV with `b`≠0: go to RUN with counter=WIDTH, `busy`=1.
  - DIVU/DIV with `b`=0: go to FIN directly, `busy`=1, divide-by-zero flag set.
  - MTHI: `hi`←`a`. MTLO: `lo`←`a`. Both complete on this edge; stay in IDLE, no `busy`, no `done`.
  - 11x: ignored entirely.
- **RUN**, one iteration per edge; the counter decrements and the state goes to FIN when it reaches 0.
  - Multiply: 2W-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract; the quotient bit is 1 when the partial remainder ≥ the divisor.
- **FIN**, one edge: apply the sign fix, write `hi`/`lo`, set `done`=1 and `busy`=0, return to IDLE.
  - Signed multiply: negate the 2W-bit product if the signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Divide by zero: `hi`/`lo` unchanged, `div_by_zero`=1.
- **Arithmetic rules**:
  - All arithmetic is modulo 2^WIDTH per half; no trap is raised.
  - DIV of most-negative by −1 gives `lo`=most-negative and `hi`=0. This falls out of the WIDTH-wrapping absolute value and needs no special case.
  - `|a|` of the most-negative value is taken as the unsigned 2^(W−1).
- **Timing of outputs**: `hi`/`lo` change only on FIN edges, MTHI/MTLO edges, and reset.

## Timing
- **Accept**: edge E0. `busy` goes high in the cycle after E0.
- **Multiply/divide latency**: RUN covers E1..E_WIDTH; FIN is E_WIDTH+1. `done`=1 and valid `hi`/`lo` appear WIDTH+1 cycles after E0 (33 for WIDTH=32).
- **Divide by zero**: FIN at E1; `done` appears 1 cycle after E0.
- **`done`**: high for exactly one cycle. `busy` is 0 in that cycle.
- **Back-to-back**: a `start` sampled in the `done` cycle is accepted. The new operation reads the just-written HI/LO state.
- **`start` while `busy`=1**: ignored. It is not queued, and the operation in flight is unaffected.
- **MTHI/MTLO**: zero-latency register write at the accept edge. The value is visible the next cycle.
- **`rst_n` low mid-operation**: aborts immediately and asynchronously; all outputs go to their reset values. No `done` pulse follows release.

## Test plan
- **MULTU**: `a`=`b`=0xFFFFFFFF → `done` 33 cycles after accept, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high for 33 cycles.
- **Signed multiply and divide**:
  - MULT −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7/2 → `lo`=3, `hi`=1.
- **Boundary divides**:
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 7/0 with `hi`=0x11, `lo`=0x22 preloaded via MTHI/MTLO → `done` 1 cycle after accept, `div_by_zero`=1, `hi`/`lo` unchanged. The next accepted `start` clears `div_by_zero`.
- **Handshake**:
  - `start` with new operands pulsed while `busy` → ignored; the result matches the first operation.
  - `start` asserted in the `done` cycle → accepted; a second `done` follows 33 cycles later.
- **Reset mid-run**: assert `rst_n`=0 at cycle 10 of a MULT → `busy`, `done`, `hi`, `lo` all 0 immediately. No `done` after release.
- **WIDTH=8 instance**: MULT 0x80×0x80 → `hi`=0x40, `lo`=0x00 after 9 cycles. DIV 0x80/0xFF → `lo`=0x80, `hi`=0.
